nfc_stream_fifo: RTL and testbench
==================================

// Module: nfc_stream_fifo
// PURPOSE
//  Parametrised synchronous FIFO that replaces the fixed 8-bit byte FIFO between the NAND
//  page reader (flash A) and the NAND page writer (flash B) in the NFC copy datapath.
//  Width, depth and almost-full/almost-empty thresholds are generic. Adds occupancy
//  count, sticky overflow/underflow error flags, a read-data-valid strobe and a
//  synchronous flush. Reader throttles on almost_full; writer starts on !empty.
// PARAMETERS
//  DATA_W    8    data word width in bits
//  DEPTH     16   number of entries; power of 2, >= 4
//  AF_LEVEL  14   almost_full asserted when count >= AF_LEVEL; range 1..DEPTH
//  AE_LEVEL  2    almost_empty asserted when count <= AE_LEVEL; range 0..DEPTH-1
//  CNT_W     $clog2(DEPTH)+1   derived local, not overridable
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        asynchronous reset, active-low
//  clr           in   1        synchronous flush
//  put           in   1        write request
//  put_data      in   DATA_W   write data
//  get           in   1        read request
//  get_data      out  DATA_W   read data, registered
//  get_valid     out  1        get_data valid strobe
//  full          out  1        count == DEPTH
//  empty         out  1        count == 0
//  almost_full   out  1        count >= AF_LEVEL
//  almost_empty  out  1        count <= AE_LEVEL
//  count         out  CNT_W    current occupancy, 0..DEPTH
//  overflow      out  1        sticky: put attempted while full and no concurrent get
//  underflow     out  1        sticky: get attempted while empty
// BEHAVIOUR
//  - Reset (rst=0): pointers=0, count=0, get_data=0, get_valid=0, full=0, empty=1,
//    almost_full=(AF_LEVEL==0 ? 1 : 0), almost_empty=1, overflow=0, underflow=0.
//    Storage array is not reset. Reset mid-transfer discards all contents.
//  - Accept rules, evaluated on state before the edge:
//      put_ok = put & (!full | get_ok);  get_ok = get & !empty.
//  - Full with put and get together: both accepted, count unchanged, no overflow.
//  - Empty with put and get together: put accepted, get rejected, underflow set,
//    count becomes 1. There is no bypass path.
//  - Read latency 1: accepted get at edge N drives get_data and get_valid=1 after
//    edge N. get_valid is high for one cycle per accepted get. get_data holds its
//    value otherwise.
//  - count' = count + put_ok - get_ok.
//  - All status flags are registered and computed from count', so they are valid in
//    the same cycle as count. No combinational path from put/get to any output.
//  - Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH. full and empty
//    come from count, not from pointer comparison.
//  - Rejected put: memory and write pointer unchanged; overflow set.
//    Rejected get: read pointer unchanged; get_valid=0; underflow set.
//  - overflow and underflow stay set until rst or clr.
//  - clr beats put and get in the same cycle. Next state: pointers=0, count=0,
//    get_valid=0, both error flags=0, flags at empty values. get_data keeps its value.
// STRUCTURE
//  - Shared package nfc_pkg holds NFC_BYTE_W=8, NFC_PAGE_BYTES, and the default
//    FIFO depth/threshold constants, for reuse by the reader and writer.
//  - Sub-module nfc_sdp_ram: simple dual-port array, one write port and one
//    registered read port, parameters DATA_W and DEPTH.
//  - Top level holds pointers, count, flags and error logic only.
// TESTING (DATA_W=8, DEPTH=16, AF=14, AE=2 unless stated)
//  1 rst low, then 20 puts of 0x00..0x13 -> accepted 0x00..0x0F; full=1 at count 16;
//    almost_full=1 from count 14; overflow=1 after 17th put; count stays 16.
//  2 From full, 16 gets -> get_data 0x00..0x0F in order, each 1 cycle after its get,
//    get_valid 16 pulses; empty=1; almost_empty=1 at count <= 2; 17th get sets underflow.
//  3 Wrap: 40 puts interleaved with gets, occupancy kept at 5 -> data in order across
//    pointer wrap; count=5 steady; no error flags.
//  4 Full plus put&get in the same cycle -> count 16, head word out, new word stored,
//    overflow=0. Empty plus put&get -> count=1, underflow=1, get_valid=0.
//  5 clr asserted with put=get=1 at count 9 -> next cycle count=0, empty=1, errors=0,
//    get_valid=0. rst dropped asynchronously mid-stream -> outputs reach reset values
//    before the next edge.
//  6 DATA_W=16, DEPTH=64, AF=60 -> 64-entry fill/drain ordering holds; almost_full
//    asserts exactly at count 60.

Source files
------------

// File: rtl/nfc_pkg.sv
// NFC copy-datapath shared constants for the page reader, page writer and the stream FIFO.
package nfc_pkg;

  localparam int NFC_BYTE_W        = 8;
  localparam int NFC_PAGE_BYTES    = 2048;
  localparam int NFC_FIFO_DEPTH    = 16;
  localparam int NFC_FIFO_AF_LEVEL = 14;
  localparam int NFC_FIFO_AE_LEVEL = 2;

endpackage

// File: rtl/nfc_sdp_ram.sv
// Simple dual-port storage: one write port and one registered read port (1-cycle latency).
// The array is not reset. The read register is reset, and it holds its value when rd_en is low.
module nfc_sdp_ram
  import nfc_pkg::*;
#(
  parameter int DATA_W = NFC_BYTE_W,
  parameter int DEPTH  = NFC_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-before-write: a read and a write to the same address in one cycle return the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/nfc_stream_fifo.sv
// Parametrised stream FIFO between the NAND page reader and the page writer. Read latency is 1 cycle.
// Upstream throttles on almost_full. Rejected puts and gets set the sticky overflow and underflow flags.
module nfc_stream_fifo
  import nfc_pkg::*;
#(
  parameter int DATA_W   = NFC_BYTE_W,
  parameter int DEPTH    = NFC_FIFO_DEPTH,
  parameter int AF_LEVEL = NFC_FIFO_AF_LEVEL,
  parameter int AE_LEVEL = NFC_FIFO_AE_LEVEL,
  localparam int CNT_W   = $clog2(DEPTH) + 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              put,
  input  logic [DATA_W-1:0] put_data,
  input  logic              get,
  output logic [DATA_W-1:0] get_data,
  output logic              get_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             put_ok, get_ok, wr_en, rd_en;
  logic [CNT_W-1:0] cnt_d;

  // A full FIFO still accepts a put when a get drains the head in the same cycle.
  always_comb begin
    get_ok = get & ~empty;
    put_ok = put & (~full | get_ok);
    wr_en  = put_ok & ~clr;
    rd_en  = get_ok & ~clr;
    cnt_d  = clr ? '0 : count + CNT_W'(put_ok) - CNT_W'(get_ok);
  end

  nfc_sdp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (put_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (get_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      get_valid    <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= (AF_LEVEL == 0);
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      // Status flags come from the next count so they line up with count itself.
      count        <= cnt_d;
      full         <= (cnt_d == CNT_W'(DEPTH));
      empty        <= (cnt_d == '0);
      almost_full  <= (cnt_d >= CNT_W'(AF_LEVEL));
      almost_empty <= (cnt_d <= CNT_W'(AE_LEVEL));
      if (clr) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        get_valid <= 1'b0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        get_valid <= get_ok;
        overflow  <= overflow  | (put & ~put_ok);
        underflow <= underflow | (get & ~get_ok);
      end
    end
  end

endmodule

// File: tb/tb_nfc_stream_fifo.sv
// Self-checking bench for nfc_stream_fifo: a default 8x16 instance and a wide 16x64 instance.
module tb_nfc_stream_fifo;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       clr = 1'b0, put = 1'b0, get = 1'b0;
  logic [7:0] put_data = 8'h00;
  logic [7:0] get_data;
  logic       get_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic        clr_w = 1'b0, put_w = 1'b0, get_w = 1'b0;
  logic [15:0] put_data_w = 16'h0000;
  logic [15:0] get_data_w;
  logic        get_valid_w, full_w, empty_w, af_w, ae_w, ovf_w, udf_w;
  logic [6:0]  count_w;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] sb[$];
  bit         m_ovf, m_udf, exp_vld;
  logic [7:0] exp_dat;

  nfc_stream_fifo dut (
    .clk(clk), .rst(rst), .clr(clr), .put(put), .put_data(put_data), .get(get),
    .get_data(get_data), .get_valid(get_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  nfc_stream_fifo #(.DATA_W(16), .DEPTH(64), .AF_LEVEL(60), .AE_LEVEL(2)) dut_w (
    .clk(clk), .rst(rst), .clr(clr_w), .put(put_w), .put_data(put_data_w), .get(get_w),
    .get_data(get_data_w), .get_valid(get_valid_w), .full(full_w), .empty(empty_w),
    .almost_full(af_w), .almost_empty(ae_w), .count(count_w),
    .overflow(ovf_w), .underflow(udf_w)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance the model by the current inputs, then clock the DUT and settle.
  task automatic tick();
    bit g_ok, p_ok;
    g_ok    = get && (sb.size() != 0);
    p_ok    = put && ((sb.size() != DEPTH) || g_ok);
    exp_vld = 1'b0;
    if (clr) begin
      sb.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (p_ok) sb.push_back(put_data);
      if (g_ok) begin
        exp_vld = 1'b1;
        exp_dat = sb.pop_front();
      end
      if (put && !p_ok) m_ovf = 1'b1;
      if (get && !g_ok) m_udf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 0; put = 0; get = 0; put_data = 0;
    clr_w = 0; put_w = 0; get_w = 0; put_data_w = 0;
    rst = 1'b0;
    sb.delete();
    m_ovf = 0; m_udf = 0; exp_vld = 0; exp_dat = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (count !== 5'd0)     begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_tests++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_tests++; if (full !== 1'b0)      begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
    n_tests++; if (almost_full !== 1'b0)  begin n_fail++; $display("FAIL reset_af got %b exp 0", almost_full); end
    n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae got %b exp 1", almost_empty); end
    n_tests++; if (overflow !== 1'b0 || underflow !== 1'b0)
      begin n_fail++; $display("FAIL reset_err got ovf=%b udf=%b exp 0 0", overflow, underflow); end
    n_tests++; if (get_valid !== 1'b0 || get_data !== 8'h00)
      begin n_fail++; $display("FAIL reset_rd got vld=%b dat=%h exp 0 00", get_valid, get_data); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 20; i++) begin
      put = 1; put_data = 8'(i);
      tick();
      n_tests++; if (count !== 5'(sb.size()))
        begin n_fail++; $display("FAIL fill_count i=%0d got %0d exp %0d", i, count, sb.size()); end
      n_tests++; if (full !== (sb.size() == DEPTH))
        begin n_fail++; $display("FAIL fill_full i=%0d got %b", i, full); end
      n_tests++; if (almost_full !== (sb.size() >= 14))
        begin n_fail++; $display("FAIL fill_af i=%0d got %b cnt %0d", i, almost_full, sb.size()); end
      n_tests++; if (overflow !== m_ovf)
        begin n_fail++; $display("FAIL fill_ovf i=%0d got %b exp %b", i, overflow, m_ovf); end
    end
    put = 0;
    n_tests++; if (count !== 5'd16 || overflow !== 1'b1)
      begin n_fail++; $display("FAIL fill_final got cnt=%0d ovf=%b exp 16 1", count, overflow); end
  endtask

  task automatic test_drain();
    int pulses = 0;
    for (int i = 0; i < 17; i++) begin
      get = 1;
      tick();
      n_tests++; if (get_valid !== exp_vld)
        begin n_fail++; $display("FAIL drain_vld i=%0d got %b exp %b", i, get_valid, exp_vld); end
      if (get_valid) pulses++;
      if (i < 16) begin
        n_tests++; if (get_data !== 8'(i))
          begin n_fail++; $display("FAIL drain_data i=%0d got %h exp %h", i, get_data, 8'(i)); end
      end
      n_tests++; if (empty !== (sb.size() == 0))
        begin n_fail++; $display("FAIL drain_empty i=%0d got %b", i, empty); end
      n_tests++; if (almost_empty !== (sb.size() <= 2))
        begin n_fail++; $display("FAIL drain_ae i=%0d got %b cnt %0d", i, almost_empty, sb.size()); end
      n_tests++; if (underflow !== m_udf)
        begin n_fail++; $display("FAIL drain_udf i=%0d got %b exp %b", i, underflow, m_udf); end
    end
    get = 0;
    n_tests++; if (pulses != 16 || underflow !== 1'b1)
      begin n_fail++; $display("FAIL drain_final got pulses=%0d udf=%b exp 16 1", pulses, underflow); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      put = 1; put_data = 8'(8'h40 + i);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      put = 1; get = 1; put_data = 8'(8'h45 + i);
      tick();
      n_tests++; if (count !== 5'd5)
        begin n_fail++; $display("FAIL wrap_count i=%0d got %0d exp 5", i, count); end
      n_tests++; if (get_valid !== 1'b1 || get_data !== exp_dat)
        begin n_fail++; $display("FAIL wrap_data i=%0d got vld=%b dat=%h exp 1 %h", i, get_valid, get_data, exp_dat); end
      n_tests++; if (overflow !== 1'b0 || underflow !== 1'b0)
        begin n_fail++; $display("FAIL wrap_err i=%0d got ovf=%b udf=%b exp 0 0", i, overflow, underflow); end
    end
    put = 0;
    for (int i = 0; i < 5; i++) begin
      get = 1;
      tick();
      n_tests++; if (get_data !== 8'(8'h68 + i))
        begin n_fail++; $display("FAIL wrap_tail i=%0d got %h exp %h", i, get_data, 8'(8'h68 + i)); end
    end
    get = 0;
  endtask

  task automatic test_concurrent();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      put = 1; put_data = 8'(8'h80 + i);
      tick();
    end
    put = 1; get = 1; put_data = 8'hAA;
    tick();
    n_tests++; if (count !== 5'd16 || full !== 1'b1)
      begin n_fail++; $display("FAIL full_pg_count got cnt=%0d full=%b exp 16 1", count, full); end
    n_tests++; if (get_valid !== 1'b1 || get_data !== 8'h80)
      begin n_fail++; $display("FAIL full_pg_head got vld=%b dat=%h exp 1 80", get_valid, get_data); end
    n_tests++; if (overflow !== 1'b0)
      begin n_fail++; $display("FAIL full_pg_ovf got %b exp 0", overflow); end
    put = 0;
    for (int i = 0; i < 16; i++) begin
      get = 1;
      tick();
      n_tests++; if (get_valid !== 1'b1 || get_data !== exp_dat)
        begin n_fail++; $display("FAIL full_pg_drain i=%0d got %h exp %h", i, get_data, exp_dat); end
    end
    n_tests++; if (get_data !== 8'hAA)
      begin n_fail++; $display("FAIL full_pg_stored got %h exp aa", get_data); end
    put = 1; get = 1; put_data = 8'h55;
    tick();
    n_tests++; if (count !== 5'd1 || underflow !== 1'b1 || get_valid !== 1'b0)
      begin n_fail++; $display("FAIL empty_pg got cnt=%0d udf=%b vld=%b exp 1 1 0", count, underflow, get_valid); end
    put = 0; get = 1;
    tick();
    n_tests++; if (get_valid !== 1'b1 || get_data !== 8'h55)
      begin n_fail++; $display("FAIL empty_pg_data got vld=%b dat=%h exp 1 55", get_valid, get_data); end
    get = 0;
  endtask

  task automatic test_clr();
    do_reset();
    get = 1; tick(); get = 0;
    for (int i = 0; i < 10; i++) begin
      put = 1; put_data = 8'(8'h10 + i);
      tick();
    end
    put = 0; get = 1; tick(); get = 0;
    n_tests++; if (count !== 5'd9 || underflow !== 1'b1 || get_data !== 8'h10)
      begin n_fail++; $display("FAIL clr_pre got cnt=%0d udf=%b dat=%h exp 9 1 10", count, underflow, get_data); end
    clr = 1; put = 1; get = 1; put_data = 8'hEE;
    tick();
    clr = 0; put = 0; get = 0;
    n_tests++; if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0)
      begin n_fail++; $display("FAIL clr_flags got cnt=%0d e=%b ae=%b f=%b af=%b", count, empty, almost_empty, full, almost_full); end
    n_tests++; if (overflow !== 1'b0 || underflow !== 1'b0 || get_valid !== 1'b0)
      begin n_fail++; $display("FAIL clr_err got ovf=%b udf=%b vld=%b exp 0 0 0", overflow, underflow, get_valid); end
    n_tests++; if (get_data !== 8'h10)
      begin n_fail++; $display("FAIL clr_hold got %h exp 10", get_data); end
    put = 1; put_data = 8'h77; tick(); put = 0;
    get = 1; tick(); get = 0;
    n_tests++; if (get_valid !== 1'b1 || get_data !== 8'h77)
      begin n_fail++; $display("FAIL clr_after got vld=%b dat=%h exp 1 77", get_valid, get_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      put = 1; put_data = 8'(8'h30 + i);
      tick();
    end
    put = 0; get = 1; tick(); get = 0;
    #2;
    rst = 1'b0;
    #1;
    n_tests++; if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1)
      begin n_fail++; $display("FAIL arst_flags got cnt=%0d e=%b ae=%b exp 0 1 1", count, empty, almost_empty); end
    n_tests++; if (get_valid !== 1'b0 || get_data !== 8'h00)
      begin n_fail++; $display("FAIL arst_rd got vld=%b dat=%h exp 0 00", get_valid, get_data); end
    do_reset();
  endtask

  task automatic test_wide();
    logic [15:0] wq[$];
    logic [15:0] w_exp;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      put_w = 1; put_data_w = 16'(16'hA000 + i * 3);
      wq.push_back(put_data_w);
      @(posedge clk); #1;
      n_tests++; if (count_w !== 7'(i + 1))
        begin n_fail++; $display("FAIL wide_count i=%0d got %0d exp %0d", i, count_w, i + 1); end
      n_tests++; if (af_w !== ((i + 1) >= 60))
        begin n_fail++; $display("FAIL wide_af cnt=%0d got %b", i + 1, af_w); end
    end
    put_w = 0;
    n_tests++; if (full_w !== 1'b1 || ovf_w !== 1'b0)
      begin n_fail++; $display("FAIL wide_full got f=%b ovf=%b exp 1 0", full_w, ovf_w); end
    for (int i = 0; i < 64; i++) begin
      get_w = 1;
      w_exp = wq.pop_front();
      @(posedge clk); #1;
      n_tests++; if (get_valid_w !== 1'b1 || get_data_w !== w_exp)
        begin n_fail++; $display("FAIL wide_data i=%0d got vld=%b dat=%h exp 1 %h", i, get_valid_w, get_data_w, w_exp); end
    end
    get_w = 0;
    n_tests++; if (empty_w !== 1'b1 || ae_w !== 1'b1 || udf_w !== 1'b0 || clr_w !== 1'b0)
      begin n_fail++; $display("FAIL wide_empty got e=%b ae=%b udf=%b exp 1 1 0", empty_w, ae_w, udf_w); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_concurrent();
    test_clr();
    test_async_reset();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
